ipv4_tx_rr_arbiter: RTL and testbench

- Parametrised successor to the fixed ICMP/TCP/UDP layer-3 transmit mux in the stack top level.
- Arbitrates NUM_PORTS layer-4 transmit sources onto the single IPv4 transmit bus. Arbitration is packet-atomic round-robin with request/grant.
- Adds an optional strict-priority port, a per-frame stall watchdog that aborts hung frames with a drop, and per-port frame counters.
- Sits between the layer-4 protocol blocks and the IPv4 protocol block.

---
 rtl/ipv4_tx_rr_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ipv4_tx_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_tx_rr_arbiter.sv
// ipv4_tx_rr_arbiter
//   Packet-atomic round-robin arbiter that merges NUM_PORTS layer-4 transmit
//   sources onto the single IPv4 transmit bus. It supports an optional
//   strict-priority port, a per-frame stall watchdog, and per-port counters.
//
// Handshake: a source raises in_req and holds it until its frame ends. When
//   the arbiter sets its in_gnt bit, the source may start the frame. Every
//   start/valid/commit/drop of the granted port is copied to out_* one cycle
//   later. Commit or drop ends the frame, and the grant drops on the same
//   edge that drives out_commit/out_drop. Strobes from non-granted ports are
//   ignored.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_req/in_gnt                  per-port request / one-hot grant
//   in_start/in_valid/in_commit/in_drop, in_bytes_valid, in_data
//                                  per-port frame bus (flattened)
//   out_start/out_valid/out_commit/out_drop, out_bytes_valid, out_data
//                                  registered copy of the granted port
//   out_port                       owner of the current or last frame
//   frames_sent/frames_aborted     per-port frame counters (flattened)
module ipv4_tx_rr_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_PORT  = -1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 32,
  localparam int BV = $clog2(DATA_WIDTH/8) + 1,
  localparam int PW = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_req,
  output logic [NUM_PORTS-1:0]             in_gnt,
  input  logic [NUM_PORTS-1:0]             in_start,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS*BV-1:0]          in_bytes_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]             in_commit,
  input  logic [NUM_PORTS-1:0]             in_drop,
  output logic                             out_start,
  output logic                             out_valid,
  output logic                             out_commit,
  output logic                             out_drop,
  output logic [BV-1:0]                    out_bytes_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [PW-1:0]                    out_port,
  output logic [NUM_PORTS*COUNT_WIDTH-1:0] frames_sent,
  output logic [NUM_PORTS*COUNT_WIDTH-1:0] frames_aborted
);

  localparam int WW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit HAS_PRIO = (PRIORITY_PORT >= 0) && (PRIORITY_PORT < NUM_PORTS);
  localparam int PRIO_IDX = HAS_PRIO ? PRIORITY_PORT : 0;

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           winner_q, winner_d;
  logic [PW-1:0]           rr_q, rr_d;
  logic [NUM_PORTS-1:0]    gnt_q, gnt_d;
  logic                    started_q, started_d;
  logic [WW-1:0]           wd_q, wd_d;
  logic                    ostart_q, ostart_d, ovalid_q, ovalid_d;
  logic                    ocommit_q, ocommit_d, odrop_q, odrop_d;
  logic [BV-1:0]           obv_q, obv_d;
  logic [DATA_WIDTH-1:0]   odata_q, odata_d;
  logic [COUNT_WIDTH-1:0]  sent_q [NUM_PORTS];
  logic [COUNT_WIDTH-1:0]  sent_d [NUM_PORTS];
  logic [COUNT_WIDTH-1:0]  abrt_q [NUM_PORTS];
  logic [COUNT_WIDTH-1:0]  abrt_d [NUM_PORTS];

  logic [PW-1:0]           sel_idx;
  logic                    sel_hit;
  logic [PW-1:0]           rr_next;
  logic                    g_req, g_start, g_valid, g_commit, g_drop;
  logic [BV-1:0]           g_bv;
  logic [DATA_WIDTH-1:0]   g_data;

  // Winner search: first requester at or above the pointer, wrapping; the
  // priority port overrides whenever it is requesting.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!sel_hit && in_req[(int'(rr_q) + i) % NUM_PORTS]) begin
        sel_hit = 1'b1;
        sel_idx = PW'((int'(rr_q) + i) % NUM_PORTS);
      end
    end
    if (HAS_PRIO && in_req[PRIO_IDX]) sel_idx = PW'(PRIO_IDX);
  end

  assign rr_next  = (int'(winner_q) == NUM_PORTS - 1) ? '0 : winner_q + PW'(1);
  assign g_req    = in_req[winner_q];
  assign g_start  = in_start[winner_q];
  assign g_valid  = in_valid[winner_q];
  assign g_commit = in_commit[winner_q];
  assign g_drop   = in_drop[winner_q];
  assign g_bv     = in_bytes_valid[int'(winner_q)*BV +: BV];
  assign g_data   = in_data[int'(winner_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    started_d = started_q;
    wd_d      = wd_q;
    ostart_d  = 1'b0;
    ovalid_d  = 1'b0;
    ocommit_d = 1'b0;
    odrop_d   = 1'b0;
    obv_d     = '0;
    odata_d   = '0;
    sent_d    = sent_q;
    abrt_d    = abrt_q;
    case (state_q)
      S_IDLE: begin
        if (|in_req) begin
          winner_d  = sel_idx;
          gnt_d     = NUM_PORTS'(1) << sel_idx;
          started_d = 1'b0;
          wd_d      = '0;
          state_d   = S_GRANTED;
        end
      end
      S_GRANTED: begin
        if (!started_q && !g_start && !g_req) begin
          // Source gave up before starting: release without any output.
          gnt_d   = '0;
          rr_d    = rr_next;
          state_d = S_IDLE;
        end else begin
          ostart_d  = g_start;
          ovalid_d  = g_valid;
          ocommit_d = g_commit & ~g_drop;
          odrop_d   = g_drop;
          obv_d     = g_valid ? g_bv : '0;
          odata_d   = g_valid ? g_data : '0;
          if (g_start) started_d = 1'b1;
          if (g_commit || g_drop) begin
            gnt_d   = '0;
            rr_d    = rr_next;
            state_d = S_IDLE;
            if (g_drop) abrt_d[winner_q] = abrt_q[winner_q] + COUNT_WIDTH'(1);
            else        sent_d[winner_q] = sent_q[winner_q] + COUNT_WIDTH'(1);
          end else if (g_start || g_valid) begin
            wd_d = '0;
          end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            // Hung frame: abort it downstream, or release quietly if it
            // never started.
            gnt_d   = '0;
            rr_d    = rr_next;
            state_d = S_IDLE;
            wd_d    = '0;
            if (started_q) begin
              odrop_d          = 1'b1;
              abrt_d[winner_q] = abrt_q[winner_q] + COUNT_WIDTH'(1);
            end
          end else begin
            wd_d = wd_q + WW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      winner_q  <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      started_q <= 1'b0;
      wd_q      <= '0;
      ostart_q  <= 1'b0;
      ovalid_q  <= 1'b0;
      ocommit_q <= 1'b0;
      odrop_q   <= 1'b0;
      obv_q     <= '0;
      odata_q   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        sent_q[i] <= '0;
        abrt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      started_q <= started_d;
      wd_q      <= wd_d;
      ostart_q  <= ostart_d;
      ovalid_q  <= ovalid_d;
      ocommit_q <= ocommit_d;
      odrop_q   <= odrop_d;
      obv_q     <= obv_d;
      odata_q   <= odata_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        sent_q[i] <= sent_d[i];
        abrt_q[i] <= abrt_d[i];
      end
    end
  end

  assign in_gnt          = gnt_q;
  assign out_start       = ostart_q;
  assign out_valid       = ovalid_q;
  assign out_commit      = ocommit_q;
  assign out_drop        = odrop_q;
  assign out_bytes_valid = obv_q;
  assign out_data        = odata_q;
  assign out_port        = winner_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    assign frames_sent[p*COUNT_WIDTH +: COUNT_WIDTH]    = sent_q[p];
    assign frames_aborted[p*COUNT_WIDTH +: COUNT_WIDTH] = abrt_q[p];
  end

endmodule

// File: tb/tb_ipv4_tx_rr_arbiter.sv
// Directed bench for ipv4_tx_rr_arbiter. It uses two instances that share
// their inputs: dut (pure round-robin) and dut_p (priority port 2). Both
// instances use a 16-cycle watchdog.
module tb_ipv4_tx_rr_arbiter;
  localparam int NP = 4, DW = 32, BV = 3, CW = 16, PW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    in_req, in_start, in_valid, in_commit, in_drop;
  logic [NP*BV-1:0] in_bv;
  logic [NP*DW-1:0] in_data;

  logic [NP-1:0] gnt, gnt_p;
  logic o_start, o_valid, o_commit, o_drop;
  logic o_start_p, o_valid_p, o_commit_p, o_drop_p;
  logic [BV-1:0] o_bv, o_bv_p;
  logic [DW-1:0] o_data, o_data_p;
  logic [PW-1:0] o_port, o_port_p;
  logic [NP*CW-1:0] f_sent, f_abort, f_sent_p, f_abort_p;

  int total = 0;
  int bad = 0;

  ipv4_tx_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PRIORITY_PORT(-1),
                       .TIMEOUT_CYCLES(16), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_gnt(gnt), .in_start(in_start),
    .in_valid(in_valid), .in_bytes_valid(in_bv), .in_data(in_data),
    .in_commit(in_commit), .in_drop(in_drop), .out_start(o_start),
    .out_valid(o_valid), .out_commit(o_commit), .out_drop(o_drop),
    .out_bytes_valid(o_bv), .out_data(o_data), .out_port(o_port),
    .frames_sent(f_sent), .frames_aborted(f_abort));

  ipv4_tx_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .PRIORITY_PORT(2),
                       .TIMEOUT_CYCLES(16), .COUNT_WIDTH(CW)) dut_p (
    .clk(clk), .rst(rst), .in_req(in_req), .in_gnt(gnt_p), .in_start(in_start),
    .in_valid(in_valid), .in_bytes_valid(in_bv), .in_data(in_data),
    .in_commit(in_commit), .in_drop(in_drop), .out_start(o_start_p),
    .out_valid(o_valid_p), .out_commit(o_commit_p), .out_drop(o_drop_p),
    .out_bytes_valid(o_bv_p), .out_data(o_data_p), .out_port(o_port_p),
    .frames_sent(f_sent_p), .frames_aborted(f_abort_p));

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    in_start = '0; in_valid = '0; in_commit = '0; in_drop = '0;
    in_bv = '0; in_data = '0;
  endtask

  task automatic drive(input int p, input logic s, input logic v,
                       input logic [BV-1:0] b, input logic [DW-1:0] d,
                       input logic c, input logic dr);
    in_start[p] = s; in_valid[p] = v; in_commit[p] = c; in_drop[p] = dr;
    in_bv[p*BV +: BV] = b;
    in_data[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_req = '0;
    clear_strobes();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (gnt === '0 && n < 6) begin
      tick();
      n++;
    end
    total++;
    assert (gnt !== '0)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=nonzero grant", tag, gnt);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input logic [NP*CW-1:0] v, input int p);
    return v[p*CW +: CW];
  endfunction

  initial begin
    // ---- reset state
    rst = 1'b1;
    in_req = '0;
    clear_strobes();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_outs", {o_start, o_valid, o_commit, o_drop, o_bv, o_port}, 0);
    chk("rst_data", o_data, 0);
    chk("rst_cnt", {f_sent, f_abort}, 0);
    do_reset();

    // ---- single port 1 frame
    in_req = 4'b0010;
    tick();
    chk("t1_gnt", gnt, 4'b0010);
    chk("t1_port", o_port, 1);
    drive(1, 1, 1, 3'd4, 32'hDEADBEEF, 0, 0);
    tick();
    chk("t1_w0", {o_start, o_valid, o_bv, o_data}, {1'b1, 1'b1, 3'd4, 32'hDEADBEEF});
    drive(1, 0, 1, 3'd4, 32'h01020304, 0, 0);
    tick();
    chk("t1_w1", {o_start, o_valid, o_bv, o_data}, {1'b0, 1'b1, 3'd4, 32'h01020304});
    drive(1, 0, 1, 3'd2, 32'h0000AABB, 0, 0);
    tick();
    chk("t1_w2", {o_valid, o_bv, o_data}, {1'b1, 3'd2, 32'h0000AABB});
    drive(1, 0, 0, 3'd0, 32'h0, 1, 0);
    in_req = '0;
    tick();
    chk("t1_commit", {o_commit, o_drop, o_valid}, 3'b100);
    chk("t1_gnt_clr", gnt, 0);
    chk("t1_sent1", cnt(f_sent, 1), 1);
    clear_strobes();
    tick();
    chk("t1_quiet", {o_commit, o_valid, o_data}, 0);

    // ---- round robin, all four ports requesting continuously
    do_reset();
    in_req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      int p;
      p = f % 4;
      wait_gnt("rr_wait");
      chk("rr_order", gnt, 4'b0001 << p);
      drive(p, 1, 1, 3'd4, 32'hA0000000 + f, 0, 0);
      tick();
      chk("rr_first", {o_start, o_valid, o_port}, {1'b1, 1'b1, PW'(p)});
      drive(p, 0, 1, 3'd4, 32'hB0000000 + f, 0, 0);
      tick();
      chk("rr_second", o_data, 32'hB0000000 + f);
      drive(p, 0, 0, 3'd0, 32'h0, 1, 0);
      tick();
      chk("rr_commit", o_commit, 1);
      chk("rr_dead", gnt, 0);
      clear_strobes();
    end
    for (int p = 0; p < 4; p++) chk("rr_sent", cnt(f_sent, p), 2);

    // ---- strict priority port 2 (dut_p) vs round robin (dut)
    do_reset();
    in_req = 4'b0001;
    tick();
    chk("pr_gnt0", gnt_p, 4'b0001);
    in_req = 4'b0111;
    drive(0, 1, 1, 3'd4, 32'hC0C0C0C0, 0, 0);
    tick();
    chk("pr_w0", o_data_p, 32'hC0C0C0C0);
    drive(0, 0, 1, 3'd4, 32'hC1C1C1C1, 0, 0);
    tick();
    chk("pr_atomic", gnt_p, 4'b0001);
    drive(0, 0, 0, 3'd0, 32'h0, 1, 0);
    in_req[0] = 1'b0;
    tick();
    chk("pr_commit", {o_commit_p, gnt_p}, {1'b1, 4'b0000});
    clear_strobes();
    tick();
    chk("pr_gnt2", {gnt_p, o_port_p}, {4'b0100, 2'd2});
    chk("rr_gnt1", gnt, 4'b0010);
    drive(2, 1, 1, 3'd4, 32'h22222222, 0, 0);
    tick();
    drive(2, 0, 0, 3'd0, 32'h0, 1, 0);
    in_req = '0;
    tick();
    chk("pr_sent", {cnt(f_sent_p, 0), cnt(f_sent_p, 2)}, {16'd1, 16'd1});
    clear_strobes();

    // ---- watchdog on port 3
    do_reset();
    in_req = 4'b1000;
    tick();
    chk("wd_gnt3", gnt, 4'b1000);
    in_req = 4'b1001;
    drive(3, 1, 1, 3'd4, 32'h33333333, 0, 0);
    tick();
    chk("wd_valid", o_valid, 1);
    clear_strobes();
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("wd_early", o_drop, 0);
    end
    tick();
    chk("wd_drop", {o_drop, o_commit, gnt}, {1'b1, 1'b0, 4'b0000});
    chk("wd_abort3", cnt(f_abort, 3), 1);
    chk("wd_sent3", cnt(f_sent, 3), 0);
    in_req[3] = 1'b0;
    tick();
    chk("wd_next0", {gnt, o_drop}, {4'b0001, 1'b0});

    // ---- non-granted port 1 noise while port 0 sends
    drive(0, 1, 1, 3'd4, 32'h11111111, 0, 0);
    drive(1, 0, 1, 3'd4, 32'h99999999, 1, 0);
    tick();
    chk("ng_w0", {o_data, o_commit}, {32'h11111111, 1'b0});
    drive(0, 0, 1, 3'd4, 32'h33334444, 0, 0);
    drive(1, 1, 0, 3'd0, 32'h0, 0, 1);
    tick();
    chk("ng_w1", {o_data, o_start, o_drop}, {32'h33334444, 1'b0, 1'b0});
    drive(0, 0, 0, 3'd0, 32'h0, 1, 0);
    drive(1, 0, 0, 3'd0, 32'h0, 1, 0);
    in_req[0] = 1'b0;
    tick();
    chk("ng_commit", {o_commit, o_drop}, 2'b10);
    chk("ng_p1cnt", {cnt(f_sent, 1), cnt(f_abort, 1)}, 0);
    chk("ng_p0sent", cnt(f_sent, 0), 1);
    clear_strobes();

    // ---- commit and drop together on port 2
    in_req = 4'b0100;
    tick();
    chk("cd_gnt2", gnt, 4'b0100);
    drive(2, 1, 1, 3'd4, 32'h55555555, 0, 0);
    tick();
    drive(2, 0, 0, 3'd0, 32'h0, 1, 1);
    in_req[2] = 1'b0;
    tick();
    chk("cd_out", {o_drop, o_commit}, 2'b10);
    chk("cd_cnt", {cnt(f_abort, 2), cnt(f_sent, 2)}, {16'd1, 16'd0});
    clear_strobes();

    // ---- silent release: request withdrawn before start
    in_req = 4'b0010;
    tick();
    chk("sr_gnt1", gnt, 4'b0010);
    in_req = '0;
    tick();
    chk("sr_release", {gnt, o_drop, o_start}, 0);
    chk("sr_cnt", cnt(f_abort, 1), 0);

    // ---- async reset mid-frame
    in_req = 4'b0010;
    tick();
    drive(1, 1, 1, 3'd4, 32'h77777777, 0, 0);
    tick();
    chk("ar_valid", o_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_outs", {gnt, o_start, o_valid, o_commit, o_drop, o_bv, o_port}, 0);
    chk("ar_data", o_data, 0);
    chk("ar_cnt", {f_sent, f_abort}, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
